// File: rtl/sp_ram_pkg.sv
// rtl/sp_ram_pkg.sv - default geometry and word type for single_port_ram
package sp_ram_pkg;
  localparam int SP_RAM_ADDR_WIDTH = 6;
  localparam int SP_RAM_DATA_WIDTH = 8;
  localparam int SP_RAM_DEPTH      = 64;

  typedef logic [SP_RAM_DATA_WIDTH-1:0] sp_ram_word_t;
endpackage

// File: rtl/sp_ram_parity.sv
// rtl/sp_ram_parity.sv - even-parity XOR reduction, shared by generate and check
module sp_ram_parity #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] data,
  output logic             parity
);
  assign parity = ^data;
endmodule

// File: rtl/single_port_ram.sv
// rtl/single_port_ram.sv - write-first single-port RAM with registered read data
// Optional per-word parity check enabled by SP_RAM_PARITY_EN.
module single_port_ram
  import sp_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = SP_RAM_ADDR_WIDTH,
  parameter int DATA_WIDTH = SP_RAM_DATA_WIDTH,
  parameter int DEPTH      = SP_RAM_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  we,
`ifdef SP_RAM_PARITY_EN
  output logic                  parity_err,
`endif
  output logic [DATA_WIDTH-1:0] q
);
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  in_range;
  logic                  wr_en;

  assign in_range = ({1'b0, addr} < DEPTH_L);
  assign wr_en    = rst_n && we && in_range;

  // Storage is deliberately unreset so it can map onto block/distributed RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[addr] <= data;
    end
  end

`ifdef SP_RAM_PARITY_EN
  logic par_mem [DEPTH];
  logic wr_par;
  logic rd_par;

  sp_ram_parity #(.WIDTH(DATA_WIDTH)) u_par_gen (
    .data   (data),
    .parity (wr_par)
  );

  sp_ram_parity #(.WIDTH(DATA_WIDTH)) u_par_chk (
    .data   (mem[addr]),
    .parity (rd_par)
  );

  always_ff @(posedge clk) begin
    if (wr_en) begin
      par_mem[addr] <= wr_par;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_err <= 1'b0;
    end else if (!in_range || we) begin
      parity_err <= 1'b0;
    end else begin
      parity_err <= rd_par ^ par_mem[addr];
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (!in_range) begin
      q <= '0;
    end else if (we) begin
      q <= data;
    end else begin
      q <= mem[addr];
    end
  end
endmodule

// File: tb/tb_single_port_ram.sv
// tb/tb_single_port_ram.sv - scoreboard bench: DEPTH=64 and DEPTH=40 instances driven in lockstep
// Parity checks are built when SP_RAM_PARITY_EN is defined.
module tb_single_port_ram;
  import sp_ram_pkg::*;

  localparam int DB = 40;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  sp_ram_word_t data = '0;
  logic [5:0]   addr = '0;
  logic         we = 1'b0;
  sp_ram_word_t q_a, q_b;
`ifdef SP_RAM_PARITY_EN
  logic         pe_a, pe_b;
`endif

  always #5 clk = ~clk;

  single_port_ram dut_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .data       (data),
    .addr       (addr),
    .we         (we),
`ifdef SP_RAM_PARITY_EN
    .parity_err (pe_a),
`endif
    .q          (q_a)
  );

  single_port_ram #(.ADDR_WIDTH(6), .DATA_WIDTH(8), .DEPTH(DB)) dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .data       (data),
    .addr       (addr),
    .we         (we),
`ifdef SP_RAM_PARITY_EN
    .parity_err (pe_b),
`endif
    .q          (q_b)
  );

  typedef struct {
    sp_ram_word_t a;
    sp_ram_word_t b;
    logic         pe_a;
  } exp_t;

  exp_t         sb [$];
  sp_ram_word_t model_a [64];
  sp_ram_word_t model_b [DB];
  int           checks = 0;
  int           failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle per operation: push expectation at drive time, pop it when q updates.
  task automatic op(input logic w, input logic [5:0] a, input sp_ram_word_t d,
                    input string tag, input logic pe_exp = 1'b0);
    exp_t e;
    we = w; addr = a; data = d;
    e.pe_a = pe_exp;
    if (w) begin
      model_a[a] = d;
      e.a = d;
      if (a < DB) begin
        model_b[a] = d;
        e.b = d;
      end else begin
        e.b = '0;
      end
    end else begin
      e.a = model_a[a];
      e.b = (a < DB) ? model_b[a] : '0;
    end
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check({tag, "_a"}, 32'(q_a), 32'(e.a));
      check({tag, "_b"}, 32'(q_b), 32'(e.b));
`ifdef SP_RAM_PARITY_EN
      check({tag, "_pe_a"}, 32'(pe_a), 32'(e.pe_a));
      check({tag, "_pe_b"}, 32'(pe_b), 32'd0);
`endif
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held with a pending write: q stays 0, nothing lands in memory.
    we = 1'b1; addr = 6'd0; data = 8'hAA;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rst_q_a", 32'(q_a), 32'd0);
      check("rst_q_b", 32'(q_b), 32'd0);
    end
    we = 1'b0;
    rst_n = 1'b1;

    op(1'b1, 6'd0, 8'h01, "wr0");
    op(1'b1, 6'd1, 8'h02, "wr1");
    op(1'b1, 6'd2, 8'h03, "wr2");
    op(1'b0, 6'd0, 8'h00, "rd0");
    op(1'b0, 6'd1, 8'h00, "rd1");
    op(1'b0, 6'd2, 8'h00, "rd2");

    op(1'b1, 6'd7, 8'h5A, "wf_5a");
    op(1'b1, 6'd7, 8'hC3, "wf_c3");
    op(1'b0, 6'd7, 8'h00, "rd7");

    op(1'b1, 6'd63, 8'hFF, "wr63");
    op(1'b0, 6'd63, 8'h00, "rd63");

    // Asynchronous clear mid-read, memory preserved.
    rst_n = 1'b0;
    #1;
    check("async_q_a", 32'(q_a), 32'd0);
    check("async_q_b", 32'(q_b), 32'd0);
    #2;
    rst_n = 1'b1;
    op(1'b0, 6'd63, 8'h00, "rd63_post_rst");

    // Second reset with write asserted must not corrupt address 0.
    @(negedge clk);
    rst_n = 1'b0; we = 1'b1; addr = 6'd0; data = 8'hAA;
    repeat (2) @(negedge clk);
    check("rst2_q_a", 32'(q_a), 32'd0);
    rst_n = 1'b1; we = 1'b0;
    op(1'b0, 6'd0, 8'h00, "rd0_post_rst");

    op(1'b1, 6'd45, 8'h77, "oor_wr45");
    op(1'b0, 6'd45, 8'h00, "oor_rd45");
    op(1'b1, 6'd39, 8'h12, "wr39");
    op(1'b0, 6'd39, 8'h00, "rd39");
    op(1'b0, 6'd40, 8'h00, "rd40");

`ifdef SP_RAM_PARITY_EN
    op(1'b1, 6'd3, 8'h01, "par_wr3");
    dut_a.par_mem[3] = ~dut_a.par_mem[3];
    op(1'b0, 6'd3, 8'h00, "par_rd3", 1'b1);
    op(1'b0, 6'd7, 8'h00, "par_rd7");
    op(1'b1, 6'd3, 8'h01, "par_fix3");
`endif

    for (int i = 0; i < 64; i++) begin
      op(1'b1, 6'(i), 8'($urandom), "fill");
    end
    for (int i = 0; i < 200; i++) begin
      op(1'($urandom), 6'($urandom_range(0, 63)), 8'($urandom), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
